// File: rtl/snax_reqrsp_to_hwpe.sv
// Bridges a 64-bit reqrsp slave port onto a 32-bit HWPE TCDM master, one transaction at a time.
// Optional: define SNAX_REQRSP_TO_HWPE_ALIGN_CHECK_EN to answer non 8-byte-aligned requests with an error.
module snax_reqrsp_to_hwpe #(
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned HwpeAddrWidth = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     q_valid_i,
    output logic                     q_ready_o,
    input  logic [AddrWidth-1:0]     q_addr_i,
    input  logic                     q_write_i,
    input  logic [DataWidth-1:0]     q_data_i,
    input  logic [DataWidth/8-1:0]   q_strb_i,
    output logic                     p_valid_o,
    input  logic                     p_ready_i,
    output logic [DataWidth-1:0]     p_data_o,
    output logic                     p_error_o,
    output logic                     tcdm_req_o,
    input  logic                     tcdm_gnt_i,
    output logic [HwpeAddrWidth-1:0] tcdm_add_o,
    output logic                     tcdm_wen_o,
    output logic [3:0]               tcdm_be_o,
    output logic [31:0]              tcdm_data_o,
    input  logic [31:0]              tcdm_r_data_i,
    input  logic                     tcdm_r_valid_i
);

    if (DataWidth != 64) begin : gen_width_check
        $error("snax_reqrsp_to_hwpe only supports DataWidth = 64");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, RESP} state_e;

    state_e                   state_q;
    logic [HwpeAddrWidth-4:0] addrHi_q;
    logic                     write_q;
    logic [63:0]              wdata_q;
    logic [7:0]               strb_q;
    logic [1:0]               beats_q;
    logic [1:0]               gntCnt_q;
    logic [1:0]               rdCnt_q;
    logic [63:0]              rdata_q;

    logic                     curHi;
    logic                     finalBeat;
    logic                     rvAccept;
    logic [1:0]               rdCntNext;
    logic [1:0]               newMask;
    logic                     alignErr;
    logic                     unusedAddr;

`ifdef SNAX_REQRSP_TO_HWPE_ALIGN_CHECK_EN
    logic err_q;
    assign unusedAddr = ^q_addr_i[AddrWidth-1:HwpeAddrWidth];
    assign p_error_o  = err_q;
`else
    assign unusedAddr = ^{q_addr_i[AddrWidth-1:HwpeAddrWidth], q_addr_i[2:0]};
    assign p_error_o  = 1'b0;
`endif

    // beats_q holds the beats still to be issued; the lo beat always goes first
    assign curHi     = ~beats_q[0];
    assign finalBeat = curHi | ~beats_q[1];

    assign q_ready_o   = (state_q == IDLE) && !rst_i;
    assign tcdm_req_o  = (state_q == ISSUE);
    assign tcdm_add_o  = {addrHi_q, curHi, 2'b00};
    assign tcdm_wen_o  = ~write_q;
    assign tcdm_be_o   = write_q ? (curHi ? strb_q[7:4] : strb_q[3:0]) : 4'hF;
    assign tcdm_data_o = curHi ? wdata_q[63:32] : wdata_q[31:0];
    assign p_valid_o   = (state_q == RESP);
    assign p_data_o    = rdata_q;

    // Read data is only taken while a granted read beat is still waiting for it
    assign rvAccept  = tcdm_r_valid_i && !write_q && (rdCnt_q < gntCnt_q) &&
                       ((state_q == ISSUE) || (state_q == WAIT_R));
    assign rdCntNext = rdCnt_q + {1'b0, rvAccept};

    always_comb begin
        newMask = 2'b11;
        if (q_write_i) begin
            newMask = {|q_strb_i[7:4], |q_strb_i[3:0]};
        end
`ifdef SNAX_REQRSP_TO_HWPE_ALIGN_CHECK_EN
        alignErr = (q_addr_i[2:0] != 3'b000);
`else
        alignErr = 1'b0;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addrHi_q <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            beats_q  <= '0;
            gntCnt_q <= '0;
            rdCnt_q  <= '0;
            rdata_q  <= '0;
`ifdef SNAX_REQRSP_TO_HWPE_ALIGN_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            if (rvAccept) begin
                if (rdCnt_q == 2'd0) rdata_q[31:0]  <= tcdm_r_data_i;
                else                 rdata_q[63:32] <= tcdm_r_data_i;
                rdCnt_q <= rdCntNext;
            end
            case (state_q)
                IDLE: begin
                    if (q_valid_i) begin
                        addrHi_q <= q_addr_i[HwpeAddrWidth-1:3];
                        write_q  <= q_write_i;
                        wdata_q  <= q_data_i;
                        strb_q   <= q_strb_i;
                        beats_q  <= alignErr ? 2'b00 : newMask;
                        gntCnt_q <= '0;
                        rdCnt_q  <= '0;
                        rdata_q  <= '0;
`ifdef SNAX_REQRSP_TO_HWPE_ALIGN_CHECK_EN
                        err_q    <= alignErr;
`endif
                        state_q  <= (alignErr || newMask == 2'b00) ? RESP : ISSUE;
                    end
                end
                ISSUE: begin
                    if (tcdm_gnt_i) begin
                        beats_q  <= curHi ? 2'b00 : {beats_q[1], 1'b0};
                        gntCnt_q <= gntCnt_q + 2'd1;
                        if (finalBeat) begin
                            state_q <= (write_q || rdCntNext == 2'd2) ? RESP : WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (rdCntNext == 2'd2) state_q <= RESP;
                end
                RESP: begin
                    if (p_ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snax_reqrsp_to_hwpe.sv
// Randomized scoreboard bench for snax_reqrsp_to_hwpe with a TCDM memory responder and a byte-level reference memory.
module tb_snax_reqrsp_to_hwpe;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        q_valid_i;
    logic        q_ready_o;
    logic [47:0] q_addr_i;
    logic        q_write_i;
    logic [63:0] q_data_i;
    logic [7:0]  q_strb_i;
    logic        p_valid_o;
    logic        p_ready_i;
    logic [63:0] p_data_o;
    logic        p_error_o;
    logic        tcdm_req_o;
    logic        tcdm_gnt_i;
    logic [31:0] tcdm_add_o;
    logic        tcdm_wen_o;
    logic [3:0]  tcdm_be_o;
    logic [31:0] tcdm_data_o;
    logic [31:0] tcdm_r_data_i;
    logic        tcdm_r_valid_i;

    snax_reqrsp_to_hwpe dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .q_valid_i(q_valid_i), .q_ready_o(q_ready_o), .q_addr_i(q_addr_i),
        .q_write_i(q_write_i), .q_data_i(q_data_i), .q_strb_i(q_strb_i),
        .p_valid_o(p_valid_o), .p_ready_i(p_ready_i), .p_data_o(p_data_o), .p_error_o(p_error_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
        .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
        .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {logic [31:0] add; logic wen; logic [3:0] be; logic [31:0] data;} beat_t;
    typedef struct {logic [63:0] data; logic err;} resp_t;
    typedef struct {logic [31:0] data; int due;} rd_t;

    beat_t expBeats[$];
    resp_t expResps[$];
    rd_t   pend[$];
    logic [31:0] slvMem [logic [31:0]];
    logic [63:0] refMem [logic [31:0]];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int gntWait = -1, gntProb = 60, holdCnt = 0, latMin = 1, latMax = 3;
    int pWait = -1, pProb = 70, pHold = 0;
    bit staleRv = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] def32(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] slvRead(input logic [31:0] a);
        return slvMem.exists(a >> 2) ? slvMem[a >> 2] : def32(a);
    endfunction

    function automatic logic [63:0] refRead(input logic [31:0] base);
        return refMem.exists(base >> 3) ? refMem[base >> 3] : {def32(base + 32'd4), def32(base)};
    endfunction

    task automatic preload(input logic [31:0] base, input logic [63:0] val);
        slvMem[base >> 2]            = val[31:0];
        slvMem[(base + 32'd4) >> 2] = val[63:32];
        refMem[base >> 3]            = val;
    endtask

    // TCDM responder: grants, serves the memory and checks every granted beat against the scoreboard
    initial begin
        logic [31:0] prevAdd, prevData, w;
        logic [3:0]  prevBe;
        bit prevStall = 0;
        beat_t b;
        tcdm_gnt_i = 0; tcdm_r_valid_i = 0; tcdm_r_data_i = 0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (rst_i) begin
                pend.delete();
                prevStall = 0;
                holdCnt = 0;
            end
            if (staleRv) begin
                tcdm_r_valid_i = 1; tcdm_r_data_i = 32'hBAD0BAD0;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                tcdm_r_valid_i = 1; tcdm_r_data_i = pend[0].data;
                void'(pend.pop_front());
            end else begin
                tcdm_r_valid_i = 0; tcdm_r_data_i = $urandom;
            end
            tcdm_gnt_i = 0;
            if (tcdm_req_o && !rst_i) begin
                if (prevStall) begin
                    checkOutput("tcdm_add_stable", tcdm_add_o, prevAdd);
                    checkOutput("tcdm_be_stable", tcdm_be_o, prevBe);
                    checkOutput("tcdm_data_stable", tcdm_data_o, prevData);
                end
                tcdm_gnt_i = (gntWait >= 0) ? (holdCnt >= gntWait) : ($urandom_range(99) < gntProb);
                if (tcdm_gnt_i) begin
                    holdCnt = 0; prevStall = 0;
                    if (expBeats.size() == 0) begin
                        checkOutput("unexpected_tcdm_beat", tcdm_add_o, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        b = expBeats.pop_front();
                        checkOutput("tcdm_add", tcdm_add_o, b.add);
                        checkOutput("tcdm_wen", tcdm_wen_o, b.wen);
                        checkOutput("tcdm_be", tcdm_be_o, b.be);
                        if (!b.wen) checkOutput("tcdm_wdata", tcdm_data_o, b.data);
                    end
                    if (tcdm_wen_o) begin
                        pend.push_back('{slvRead(tcdm_add_o), cyc + $urandom_range(latMax, latMin)});
                    end else begin
                        w = slvRead(tcdm_add_o);
                        for (int i = 0; i < 4; i++) if (tcdm_be_o[i]) w[8*i +: 8] = tcdm_data_o[8*i +: 8];
                        slvMem[tcdm_add_o >> 2] = w;
                    end
                end else begin
                    holdCnt++; prevStall = 1;
                    prevAdd = tcdm_add_o; prevBe = tcdm_be_o; prevData = tcdm_data_o;
                end
            end else begin
                prevStall = 0; holdCnt = 0;
            end
        end
    end

    // Response monitor: drives p_ready and compares each handshaken response with the scoreboard
    initial begin
        logic [63:0] prevPdata;
        bit prevPv = 0;
        resp_t r;
        p_ready_i = 0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                p_ready_i = 0; prevPv = 0; pHold = 0;
            end else if (p_valid_o) begin
                checkOutput("q_ready_low_in_resp", q_ready_o, 0);
                if (prevPv) checkOutput("p_data_stable", p_data_o, prevPdata);
                p_ready_i = (pWait >= 0) ? (pHold >= pWait) : ($urandom_range(99) < pProb);
                if (p_ready_i) begin
                    prevPv = 0; pHold = 0;
                    if (expResps.size() == 0) begin
                        checkOutput("unexpected_resp", p_data_o, ~p_data_o);
                    end else begin
                        r = expResps.pop_front();
                        checkOutput("p_data", p_data_o, r.data);
                        checkOutput("p_error", p_error_o, r.err);
                    end
                end else begin
                    prevPv = 1; prevPdata = p_data_o; pHold++;
                end
            end else begin
                p_ready_i = $urandom_range(1, 0);
                prevPv = 0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (tcdm_req_o && q_ready_o) checkOutput("q_ready_low_in_issue", q_ready_o, 0);
    end

    task automatic applyStimulus(input logic [47:0] addr, input bit wr, input logic [63:0] data,
                                 input logic [7:0] strb);
        logic [31:0] base;
        logic [63:0] cur;
        bit err;
        int nb = 0;
        int guard = 0;
        base = {addr[31:3], 3'b000};
        err = 0;
`ifdef SNAX_REQRSP_TO_HWPE_ALIGN_CHECK_EN
        err = (addr[2:0] != 3'b000);
`endif
        if (err) begin
            expResps.push_back('{64'd0, 1'b1});
        end else if (!wr) begin
            expBeats.push_back('{base, 1'b1, 4'hF, 32'd0});
            expBeats.push_back('{base + 32'd4, 1'b1, 4'hF, 32'd0});
            expResps.push_back('{refRead(base), 1'b0});
            nb = 2;
        end else begin
            cur = refRead(base);
            for (int h = 0; h < 2; h++) begin
                if (strb[4*h +: 4] != 4'h0) begin
                    expBeats.push_back('{base + 32'(4 * h), 1'b0, strb[4*h +: 4], data[32*h +: 32]});
                    nb++;
                end
            end
            for (int i = 0; i < 8; i++) if (strb[i]) cur[8*i +: 8] = data[8*i +: 8];
            refMem[base >> 3] = cur;
            expResps.push_back('{64'd0, 1'b0});
        end
        @(negedge clk_i);
        q_valid_i = 1; q_addr_i = addr; q_write_i = wr; q_data_i = data; q_strb_i = strb;
        while (!q_ready_o && guard < 500) begin
            @(negedge clk_i);
            guard++;
        end
        checkOutput("q_accept_in_time", (guard < 500), 1);
        @(posedge clk_i);
        #1;
        q_valid_i = 0; q_addr_i = {16'h0, $urandom}; q_write_i = $urandom_range(1, 0);
        q_data_i = {$urandom, $urandom}; q_strb_i = 8'($urandom);
        @(negedge clk_i);
        if (nb > 0) checkOutput("first_req_latency", tcdm_req_o, 1);
        else        checkOutput("direct_resp_latency", p_valid_o, 1);
    endtask

    task automatic waitDone();
        int guard = 0;
        while ((expResps.size() != 0 || expBeats.size() != 0) && guard < 3000) begin
            @(negedge clk_i);
            guard++;
        end
        checkOutput("txn_drain", (guard < 3000), 1);
        @(negedge clk_i);
    endtask

    initial begin
        logic [47:0] a;
        q_valid_i = 0; q_addr_i = '0; q_write_i = 0; q_data_i = '0; q_strb_i = '0;
        rst_i = 1;
        repeat (3) @(negedge clk_i);
        checkOutput("rst_tcdm_req", tcdm_req_o, 0);
        checkOutput("rst_p_valid", p_valid_o, 0);
        checkOutput("rst_p_error", p_error_o, 0);
        checkOutput("rst_p_data", p_data_o, 0);
        checkOutput("rst_q_ready", q_ready_o, 0);
        rst_i = 0;
        @(negedge clk_i);
        checkOutput("idle_q_ready", q_ready_o, 1);

        // Directed: read with immediate grants and single-cycle read latency
        gntWait = 0; latMin = 1; latMax = 1;
        preload(32'h1000_0000, 64'h1234abcd_deadbeef);
        applyStimulus(48'h0000_1000_0000, 0, 64'h0, 8'h00);
        waitDone();
        applyStimulus(48'h0000_2000_0008, 1, 64'hfeed5678_c0debabe, 8'hF0);
        waitDone();
        applyStimulus(48'h0000_2000_0008, 0, 64'h0, 8'h00);
        waitDone();
        applyStimulus(48'h0000_2000_0010, 1, 64'h1111_2222_3333_4444, 8'h00);
        waitDone();

        // Stalls: grants held off three cycles, response ready held off two
        gntWait = 3; pWait = 2; latMax = 3;
        applyStimulus(48'h0000_1000_0000, 0, 64'h0, 8'h00);
        applyStimulus(48'h0000_1000_0008, 1, 64'hAAAA_BBBB_CCCC_DDDD, 8'h3C);
        applyStimulus(48'h0000_1000_0008, 0, 64'h0, 8'h00);
        waitDone();

        // Reset while a request is being presented, then a stale read response
        gntWait = 100000; pWait = -1;
        applyStimulus(48'h0000_1000_0040, 0, 64'h0, 8'h00);
        repeat (2) @(negedge clk_i);
        rst_i = 1;
        @(negedge clk_i);
        checkOutput("mid_rst_tcdm_req", tcdm_req_o, 0);
        checkOutput("mid_rst_q_ready", q_ready_o, 0);
        expBeats.delete();
        expResps.delete();
        rst_i = 0;
        staleRv = 1;
        @(negedge clk_i);
        staleRv = 0;
        checkOutput("post_rst_no_resp", p_valid_o, 0);
        gntWait = -1;
        applyStimulus(48'h0000_1000_0000, 0, 64'h0, 8'h00);
        waitDone();

        // Randomized traffic over a small window so reads observe earlier writes
        latMin = 1; latMax = 4;
        for (int n = 0; n < 80; n++) begin
            logic [7:0] s;
            a = {16'h0, 32'h3000_0000 | (32'($urandom_range(15, 0)) << 3)};
            if ($urandom_range(3, 0) == 0) a[2:0] = 3'($urandom_range(7, 0));
            case ($urandom_range(3, 0))
                0: s = 8'h00;
                1: s = 8'hFF;
                default: s = 8'($urandom);
            endcase
            applyStimulus(a, $urandom_range(1, 0), {$urandom, $urandom}, s);
        end
        waitDone();

`ifdef SNAX_REQRSP_TO_HWPE_ALIGN_CHECK_EN
        applyStimulus(48'h0000_1000_0004, 0, 64'h0, 8'h00);
        waitDone();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
